// File: rtl/digit_serial_adder_ctrl_pkg.sv
// Shared definitions for the digit-serial adder sequencer.
package digit_serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/digit_serial_adder_ctrl_twobit_adder.sv
// Two-bit ripple slice: the only carry chain in the serial adder datapath.
module twobit_adder (
  input  logic [1:0] in_1,
  input  logic [1:0] in_2,
  input  logic       c_in,
  output logic [1:0] sum,
  output logic       c_out
);

  assign {c_out, sum} = {1'b0, in_1} + {1'b0, in_2} + {2'b00, c_in};

endmodule

// File: rtl/digit_serial_adder_ctrl.sv
// Digit-serial adder: WIDTH-bit add performed 2 bits per clock through one twobit_adder.
//   state   | meaning
//   IDLE    | ready for start; operands captured on accepted start
//   RUN     | one 2-bit digit added per cycle, NDIG cycles
//   DONE    | one-cycle done pulse; sum/c_out/overflow valid
module digit_serial_adder_ctrl
  import digit_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NDIG = WIDTH / 2;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [1:0]       slice_sum;
  logic             slice_co;
  logic [WIDTH+1:0] res_ext;
  logic [WIDTH-1:0] res_next;

  twobit_adder u_slice (
    .in_1  (a_sh_q[1:0]),
    .in_2  (b_sh_q[1:0]),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_co)
  );

  // New digit enters at the top; concatenation keeps WIDTH=2 legal.
  assign res_ext  = {slice_sum, res_sh_q};
  assign res_next = res_ext[WIDTH+1:2];

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        carry_d  = slice_co;
        a_sh_d   = a_sh_q >> 2;
        b_sh_d   = b_sh_q >> 2;
        res_sh_d = res_next;
        cnt_d    = cnt_q + CW'(1);
        // Outputs load only here so partial results never appear.
        if (cnt_q == LAST_DIG) begin
          state_d = ST_DONE;
          sum_d   = res_next;
          c_out_d = slice_co;
          ovf_d   = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule
